// File: rtl/button_press_decoder.sv
// Push-button front end: 2-flop synchronizer, debounce FSM, and short/long press classification.
// All event outputs are registered single-cycle pulses in the clk domain.
module button_press_decoder #(
  parameter int unsigned DEBOUNCE_COUNT = 999_999,
  parameter int unsigned LONG_COUNT     = 49_999_999,
  parameter bit          ACTIVE_LOW     = 1'b0
) (
  input  logic clk,
  input  logic clear,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press
);

  localparam int unsigned DB_W   = (DEBOUNCE_COUNT > 0) ? $clog2(DEBOUNCE_COUNT + 1) : 1;
  localparam int unsigned HOLD_W = (LONG_COUNT > 0) ? $clog2(LONG_COUNT + 1) : 1;

  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_COUNT);
  localparam logic [DB_W-1:0]   DB_ZERO  = DB_W'(0);
  localparam logic [DB_W-1:0]   DB_ONE   = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_COUNT);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic               long_fired_q, long_fired_d;
  logic               btn_level_q, btn_level_d;
  logic               press_pulse_q, press_pulse_d;
  logic               release_pulse_q, release_pulse_d;
  logic               short_press_q, short_press_d;
  logic               long_press_q, long_press_d;

  logic               btn_sync;
  logic [HOLD_W-1:0]  hold_inc;
  logic               long_hit;

  // Polarity is folded in ahead of the first flop so a cleared synchronizer always reads "released".
  assign btn_sync = sync2_q;
  assign hold_inc = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : (hold_cnt_q + HOLD_ONE);
  assign long_hit = ((state_q == HELD) || (state_q == DB_RELEASE)) &&
                    (hold_cnt_q == HOLD_MAX) && !long_fired_q;

  // Next-state, counter and pulse computation.
  always_comb begin
    sync1_d         = btn_in ^ ACTIVE_LOW;
    sync2_d         = sync1_q;
    state_d         = state_q;
    db_cnt_d        = db_cnt_q;
    hold_cnt_d      = hold_cnt_q;
    long_fired_d    = long_fired_q;
    btn_level_d     = btn_level_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    short_press_d   = 1'b0;
    long_press_d    = 1'b0;

    if (long_hit) begin
      long_press_d = 1'b1;
      long_fired_d = 1'b1;
    end else begin
      long_press_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (btn_sync) begin
          state_d  = DB_PRESS;
          db_cnt_d = DB_ZERO;
        end else begin
          state_d = IDLE;
        end
      end
      DB_PRESS: begin
        if (!btn_sync) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_MAX) begin
          state_d       = HELD;
          btn_level_d   = 1'b1;
          press_pulse_d = 1'b1;
          hold_cnt_d    = HOLD_ZERO;
          long_fired_d  = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      HELD: begin
        hold_cnt_d = hold_inc;
        if (!btn_sync) begin
          state_d  = DB_RELEASE;
          db_cnt_d = DB_ZERO;
        end else begin
          state_d = HELD;
        end
      end
      DB_RELEASE: begin
        // A release glitch returns to HELD without restarting the hold count.
        hold_cnt_d = hold_inc;
        if (btn_sync) begin
          state_d = HELD;
        end else if (db_cnt_q == DB_MAX) begin
          state_d         = IDLE;
          btn_level_d     = 1'b0;
          release_pulse_d = 1'b1;
          short_press_d   = !long_fired_q && !long_hit;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      default: begin
        state_d     = IDLE;
        btn_level_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q         <= IDLE;
      sync1_q         <= 1'b0;
      sync2_q         <= 1'b0;
      db_cnt_q        <= DB_ZERO;
      hold_cnt_q      <= HOLD_ZERO;
      long_fired_q    <= 1'b0;
      btn_level_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      short_press_q   <= 1'b0;
      long_press_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      db_cnt_q        <= db_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      long_fired_q    <= long_fired_d;
      btn_level_q     <= btn_level_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      short_press_q   <= short_press_d;
      long_press_q    <= long_press_d;
    end
  end

  assign btn_level     = btn_level_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign short_press   = short_press_q;
  assign long_press    = long_press_q;

endmodule

// File: tb/tb_button_press_decoder.sv
// Directed bench for button_press_decoder: one active-high and one active-low instance
// with DEBOUNCE_COUNT=3, LONG_COUNT=20; event edges are counted from the stimulus change.
module tb_button_press_decoder;

  logic clk = 1'b0;
  logic clear;
  logic btn_a, btn_b;
  logic lvl_a, pp_a, rp_a, sp_a, lp_a;
  logic lvl_b, pp_b, rp_b, sp_b, lp_b;

  int total = 0;
  int bad   = 0;

  // Edge index within the current window (first edge = 1) and first-edge / count trackers; 0 = none.
  int ecnt, pp_first, pp_cnt, rp_first, rp_cnt, sp_first, sp_cnt, lp_first, lp_cnt;
  int lvl_rise, lvl_fall, bpp_first, bpp_cnt;
  logic lvl_prev;

  button_press_decoder #(.DEBOUNCE_COUNT(3), .LONG_COUNT(20), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .clear(clear), .btn_in(btn_a), .btn_level(lvl_a), .press_pulse(pp_a),
    .release_pulse(rp_a), .short_press(sp_a), .long_press(lp_a)
  );

  button_press_decoder #(.DEBOUNCE_COUNT(3), .LONG_COUNT(20), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .clear(clear), .btn_in(btn_b), .btn_level(lvl_b), .press_pulse(pp_b),
    .release_pulse(rp_b), .short_press(sp_b), .long_press(lp_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic trk_reset();
    ecnt = 0; pp_first = 0; pp_cnt = 0; rp_first = 0; rp_cnt = 0;
    sp_first = 0; sp_cnt = 0; lp_first = 0; lp_cnt = 0;
    lvl_rise = 0; lvl_fall = 0; bpp_first = 0; bpp_cnt = 0;
    lvl_prev = lvl_a;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      ecnt++;
      if (pp_a) begin pp_cnt++; if (pp_first == 0) pp_first = ecnt; end
      if (rp_a) begin rp_cnt++; if (rp_first == 0) rp_first = ecnt; end
      if (sp_a) begin sp_cnt++; if (sp_first == 0) sp_first = ecnt; end
      if (lp_a) begin lp_cnt++; if (lp_first == 0) lp_first = ecnt; end
      if (pp_b) begin bpp_cnt++; if (bpp_first == 0) bpp_first = ecnt; end
      if (lvl_a && !lvl_prev && lvl_rise == 0) lvl_rise = ecnt;
      if (!lvl_a && lvl_prev && lvl_fall == 0) lvl_fall = ecnt;
      lvl_prev = lvl_a;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_a"}, int'({lvl_a, pp_a, rp_a, sp_a, lp_a}), 0);
    check_eq({tag, "_b"}, int'({lvl_b, pp_b, rp_b, sp_b, lp_b}), 0);
  endtask

  task automatic do_reset();
    clear = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("rst_hold");
    clear = 1'b0;
  endtask

  initial begin
    clear = 1'b1;
    btn_a = 1'b0;
    btn_b = 1'b1;
    #2;
    check_all_zero("rst_init");
    do_reset();

    // 1: stable press -> level and press pulse at edge 7, pulse one cycle wide
    btn_a = 1'b1;
    trk_reset(); run(7);
    check_eq("t1_pp_edge", pp_first, 7);
    check_eq("t1_lvl_edge", lvl_rise, 7);
    check_eq("t1_pp_cnt", pp_cnt, 1);
    check_eq("t1_b_idle", bpp_cnt, 0);
    trk_reset(); run(10);
    check_eq("t1_pp_width", pp_cnt, 0);
    check_eq("t1_lvl_held", int'(lvl_a), 1);

    // 2: release after 10 held cycles -> short press with release, 7 edges later
    btn_a = 1'b0;
    trk_reset(); run(10);
    check_eq("t2_rp_edge", rp_first, 7);
    check_eq("t2_sp_edge", sp_first, 7);
    check_eq("t2_lvl_fall", lvl_fall, 7);
    check_eq("t2_rp_cnt", rp_cnt, 1);
    check_eq("t2_sp_cnt", sp_cnt, 1);
    check_eq("t2_lp_cnt", lp_cnt, 0);

    // 3: long hold -> long press 21 cycles after level rise, no short on release
    btn_a = 1'b1;
    trk_reset(); run(7);
    check_eq("t3_pp_edge", pp_first, 7);
    trk_reset(); run(40);
    check_eq("t3_lp_edge", lp_first, 21);
    check_eq("t3_lp_cnt", lp_cnt, 1);
    btn_a = 1'b0;
    trk_reset(); run(10);
    check_eq("t3_rp_edge", rp_first, 7);
    check_eq("t3_sp_cnt", sp_cnt, 0);
    check_eq("t3_lp_again", lp_cnt, 0);

    // 3b: long threshold lands on the release-accept edge -> long wins, no short
    btn_a = 1'b1;
    trk_reset(); run(7);
    trk_reset(); run(14);
    check_eq("t3b_lp_early", lp_cnt, 0);
    btn_a = 1'b0;
    trk_reset(); run(10);
    check_eq("t3b_rp_edge", rp_first, 7);
    check_eq("t3b_lp_edge", lp_first, 7);
    check_eq("t3b_sp_cnt", sp_cnt, 0);

    // 4: two-cycle bounce -> nothing
    btn_a = 1'b1;
    trk_reset(); run(2);
    btn_a = 1'b0;
    run(15);
    check_eq("t4_pp_cnt", pp_cnt, 0);
    check_eq("t4_lvl_rise", lvl_rise, 0);
    check_eq("t4_evt_cnt", rp_cnt + sp_cnt + lp_cnt, 0);

    // 5: release glitch at hold_cnt=8 -> no release, long still at 21
    btn_a = 1'b1;
    trk_reset(); run(7);
    check_eq("t5_pp_edge", pp_first, 7);
    trk_reset(); run(8);
    btn_a = 1'b0;
    run(2);
    btn_a = 1'b1;
    run(30);
    check_eq("t5_lp_edge", lp_first, 21);
    check_eq("t5_lp_cnt", lp_cnt, 1);
    check_eq("t5_rp_cnt", rp_cnt, 0);
    check_eq("t5_lvl_fall", lvl_fall, 0);
    btn_a = 1'b0;
    trk_reset(); run(10);
    check_eq("t5_rel_edge", rp_first, 7);
    check_eq("t5_sp_cnt", sp_cnt, 0);

    // 6: clear while held at hold_cnt=10, button kept high -> full re-detect
    btn_a = 1'b1;
    trk_reset(); run(7);
    run(10);
    check_eq("t6_lvl_before", int'(lvl_a), 1);
    clear = 1'b1;
    #1;
    check_eq("t6_lvl_async", int'(lvl_a), 0);
    @(posedge clk);
    #1;
    check_all_zero("t6_clear");
    clear = 1'b0;
    trk_reset(); run(8);
    check_eq("t6_pp_edge", pp_first, 7);
    check_eq("t6_lvl_edge", lvl_rise, 7);
    check_eq("t6_no_rel", rp_cnt + sp_cnt, 0);

    // 7: active-low instance, btn_b 1->0 -> press pulse at edge 7
    btn_a = 1'b0;
    do_reset();
    btn_b = 1'b0;
    trk_reset(); run(8);
    check_eq("t7_pp_edge", bpp_first, 7);
    check_eq("t7_pp_cnt", bpp_cnt, 1);
    check_eq("t7_lvl", int'(lvl_b), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
